// File: rtl/jt49_dcblock.sv
// DC-blocking output stage for the PSG: leaky-integrator DC removal, master gain,
// and saturation to signed 16-bit PCM, with a per-sample clip flag.
module jt49_dcblock #(
    parameter int DC_SHIFT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               sample,
    input  logic [9:0]         din,
    input  logic [7:0]         gain,
    input  logic               mute,
    output logic signed [15:0] dout,
    output logic               dout_valid,
    output logic               clip
);

    localparam int DW = 10 + DC_SHIFT;

    logic [DW-1:0]      dc;
    logic               primed;
    logic [9:0]         dc_int;
    logic               accept;
    logic signed [DW:0] delta;
    logic [DW-1:0]      dc_step;
    logic [DW-1:0]      dc_next;
    logic signed [10:0] diff_c;
    logic signed [10:0] diff_q;
    logic signed [19:0] prod_c;
    logic signed [19:0] prod_q;
    logic signed [17:0] s_c;
    logic               v1;
    logic               v2;

    assign accept  = cen & sample;
    assign dc_int  = dc[DW-1:DC_SHIFT];
    assign diff_c  = $signed({1'b0, din}) - $signed({1'b0, dc_int});
    assign delta   = $signed({1'b0, din, {DC_SHIFT{1'b0}}}) - $signed({1'b0, dc});
    // The DC estimate stays in [0, 1023<<DC_SHIFT], so a wrap-around add of the
    // truncated two's-complement step yields the exact new estimate.
    assign dc_step = DW'(delta >>> DC_SHIFT);
    assign dc_next = dc + dc_step;
    assign prod_c  = $signed({{9{diff_q[10]}}, diff_q}) * $signed({12'b0, gain});
    assign s_c     = 18'(prod_q >>> 2);

    // NOTE: all state here uses non-blocking assignments so every stage reads
    // the previous clock's values, which is what makes the pipeline a pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            dc         <= '0;
            primed     <= 1'b0;
            diff_q     <= '0;
            prod_q     <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            clip       <= 1'b0;
        end else begin
            v1         <= accept;
            v2         <= v1;
            dout_valid <= v2;

            if (accept) begin
                if (!primed) begin
                    // Warm start avoids a thump from a large initial offset.
                    dc     <= {din, {DC_SHIFT{1'b0}}};
                    primed <= 1'b1;
                    diff_q <= '0;
                end else begin
                    dc     <= dc_next;
                    diff_q <= diff_c;
                end
            end

            if (v1) prod_q <= prod_c;

            if (v2) begin
                if (mute) begin
                    dout <= '0;
                    clip <= 1'b0;
                end else if (s_c > 18'sd32767) begin
                    dout <= 16'sh7fff;
                    clip <= 1'b1;
                end else if (s_c < -18'sd32768) begin
                    dout <= -16'sh8000;
                    clip <= 1'b1;
                end else begin
                    dout <= s_c[15:0];
                    clip <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_jt49_dcblock.sv
// Self-checking bench for jt49_dcblock: directed scenarios plus random traffic,
// all compared against an integer scoreboard model of the DC blocker.
module tb_jt49_dcblock;

    localparam int S = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cen = 1'b0;
    logic               sample = 1'b0;
    logic [9:0]         din = '0;
    logic [7:0]         gain = 8'd128;
    logic               mute = 1'b0;
    logic signed [15:0] dout;
    logic               dout_valid;
    logic               clip;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    jt49_dcblock #(.DC_SHIFT(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .sample    (sample),
        .din       (din),
        .gain      (gain),
        .mute      (mute),
        .dout      (dout),
        .dout_valid(dout_valid),
        .clip      (clip)
    );

    // Scoreboard: each accepted sample waits in a queue until its output edge.
    typedef struct {
        int due;
        int diff;
        int g;
    } pend_t;

    pend_t q[$];
    int    cyc = 0;
    int    m_dc = 0;
    bit    m_primed = 1'b0;
    int    e_dout = 0;
    bit    e_valid = 1'b0;
    bit    e_clip = 1'b0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model the edge about to happen from the current inputs, then clock and compare.
    task automatic tick();
        pend_t p;
        int    s;
        cyc++;
        if (rst) begin
            q.delete();
            m_primed = 1'b0;
            m_dc     = 0;
            e_valid  = 1'b0;
            e_dout   = 0;
            e_clip   = 1'b0;
        end else begin
            e_valid = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                p = q.pop_front();
                s = (p.diff * p.g) >>> 2;
                e_valid = 1'b1;
                if (mute) begin
                    e_dout = 0;      e_clip = 1'b0;
                end else if (s > 32767) begin
                    e_dout = 32767;  e_clip = 1'b1;
                end else if (s < -32768) begin
                    e_dout = -32768; e_clip = 1'b1;
                end else begin
                    e_dout = s;      e_clip = 1'b0;
                end
            end
            foreach (q[i]) if (q[i].due == cyc + 1) q[i].g = int'(gain);
            if (cen && sample) begin
                p.due = cyc + 2;
                p.g   = 0;
                if (!m_primed) begin
                    m_primed = 1'b1;
                    m_dc     = int'(din) * (1 << S);
                    p.diff   = 0;
                end else begin
                    p.diff = int'(din) - (m_dc >>> S);
                    m_dc   = m_dc + ((int'(din) * (1 << S) - m_dc) >>> S);
                end
                q.push_back(p);
            end
        end
        @(posedge clk);
        #1;
        check("valid", dout_valid, e_valid);
        check("dout", dout, e_dout);
        check("clip", clip, e_clip);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input int d);
        cen = 1'b1; sample = 1'b1; din = 10'(d);
        tick();
        cen = 1'b0; sample = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        int prev;

        do_reset();
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_clip", clip, 0);

        // Priming sample produces silence.
        gain = 8'd128;
        send(512);
        idle(2);
        check("prime_valid", dout_valid, 1);
        check("prime_dout", dout, 0);

        // Step from 0 to 1000 and its decay.
        do_reset();
        send(0);
        send(1000);
        idle(2);
        check("step1", dout, 32000);
        send(1000);
        idle(2);
        check("step2", dout, 31904);
        prev = int'(dout);
        for (int i = 0; i < 15; i++) begin
            send(1000);
            idle(2);
            check("decay", int'(dout < prev && dout >= 0), 1);
            prev = int'(dout);
        end

        // Saturation in both directions.
        do_reset();
        gain = 8'd255;
        send(0);
        send(1023);
        idle(2);
        check("sat_pos", dout, 32767);
        check("sat_pos_clip", clip, 1);
        do_reset();
        send(1023);
        send(0);
        idle(2);
        check("sat_neg", dout, -32768);
        check("sat_neg_clip", clip, 1);

        // Mute while the tracker keeps running, then cen gating.
        do_reset();
        gain = 8'd128;
        send(0);
        mute = 1'b1;
        send(1000);
        send(1000);
        idle(2);
        check("mute_dout", dout, 0);
        mute = 1'b0;
        send(1000);
        idle(2);
        cen = 1'b0; sample = 1'b1; din = 10'd777;
        idle(4);
        sample = 1'b0;
        send(1000);
        idle(2);

        // Reset while a sample is in flight.
        do_reset();
        send(0);
        idle(2);
        send(500);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(4);
        check("midrst_dout", dout, 0);
        send(300);
        idle(2);
        check("reprime_valid", dout_valid, 1);
        check("reprime_dout", dout, 0);

        // Back-to-back throughput.
        do_reset();
        gain = 8'd128;
        send(0);
        send(100);
        send(200);
        check("tp0", dout, 0);
        check("tp0_valid", dout_valid, 1);
        idle(1);
        check("tp1", dout, 3200);
        check("tp1_valid", dout_valid, 1);
        idle(1);
        check("tp2", dout, 6400);
        check("tp2_valid", dout_valid, 1);
        idle(1);
        check("tp_end_valid", dout_valid, 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 149) == 0);
            cen    = ($urandom_range(0, 3) != 0);
            sample = ($urandom_range(0, 2) != 0);
            din    = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 7) == 0) gain = 8'($urandom_range(0, 255));
            mute   = ($urandom_range(0, 9) == 0);
            tick();
        end
        rst = 1'b0; cen = 1'b0; sample = 1'b0; mute = 1'b0;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
